// File: rtl/decompress_pkg.sv
// Shared widths, FSM state type, dequantisation table and Q1.14 IDCT basis for decompress_block.
package decompress_pkg;

    localparam int unsigned BLOCK_SIZE = 8;
    localparam int unsigned NUM_COEF   = 64;
    localparam int unsigned IDX_WIDTH  = 6;
    localparam int unsigned COEF_WIDTH = 12;
    localparam int unsigned DQ_WIDTH   = 20;
    localparam int unsigned MID_WIDTH  = 24;
    localparam int unsigned PIX_WIDTH  = 9;
    localparam int unsigned Q_WIDTH    = 8;
    localparam int unsigned T_WIDTH    = 16;
    localparam int unsigned ACC_WIDTH  = 48;
    localparam int unsigned RND_SHIFT  = 14;
    localparam int unsigned DOT_WIDTH  = ACC_WIDTH - RND_SHIFT;

    localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1 << (RND_SHIFT - 1));
    localparam logic signed [DOT_WIDTH-1:0] PIX_MAX  = DOT_WIDTH'(255);
    localparam logic signed [DOT_WIDTH-1:0] PIX_MIN  = DOT_WIDTH'(-256);

    typedef enum logic [1:0] {S_LOAD, S_ROW, S_COL, S_OUT} state_t;

    // Standard JPEG luminance quantisation table, raster order.
    localparam logic [Q_WIDTH-1:0] QTAB [NUM_COEF] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    // IDCT basis T[k][n] in Q1.14, flattened as k*8+n (k = frequency, n = sample).
    localparam logic signed [T_WIDTH-1:0] TTAB [NUM_COEF] = '{
         16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
         16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
         16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
         16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
         16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
         16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
         16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
         16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
    };

    function automatic logic signed [PIX_WIDTH-1:0] sat_pix(input logic signed [DOT_WIDTH-1:0] v);
        logic signed [PIX_WIDTH-1:0] res;
        if (v > PIX_MAX)      res = PIX_WIDTH'(PIX_MAX);
        else if (v < PIX_MIN) res = PIX_WIDTH'(PIX_MIN);
        else                  res = PIX_WIDTH'(v);
        return res;
    endfunction

endpackage

// File: rtl/decompress_block_if.sv
// Coefficient-in / pixel-out handshake bundle for decompress_block.
interface decompress_block_if;
    import decompress_pkg::*;

    logic                         coef_in_valid;
    logic                         coef_in_ready;
    logic signed [COEF_WIDTH-1:0] coef_in;
    logic                         pix_out_valid;
    logic                         pix_out_ready;
    logic signed [PIX_WIDTH-1:0]  pix_out;
    logic                         block_done;

    modport master (
        output coef_in_valid, coef_in, pix_out_ready,
        input  coef_in_ready, pix_out_valid, pix_out, block_done
    );

    modport slave (
        input  coef_in_valid, coef_in, pix_out_ready,
        output coef_in_ready, pix_out_valid, pix_out, block_done
    );

endinterface

// File: rtl/idct_dot8.sv
// Combinational 8-way signed dot product with round-half-up and arithmetic shift by RND_SHIFT.
module idct_dot8
    import decompress_pkg::*;
(
    input  logic signed [MID_WIDTH-1:0] i_a [BLOCK_SIZE],
    input  logic signed [T_WIDTH-1:0]   i_b [BLOCK_SIZE],
    output logic signed [DOT_WIDTH-1:0] o_y_c
);

    logic signed [ACC_WIDTH-1:0] w_acc;

    always_comb begin
        w_acc = RND_HALF;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            w_acc = w_acc + ACC_WIDTH'(i_a[i]) * ACC_WIDTH'(i_b[i]);
        end
    end

    assign o_y_c = DOT_WIDTH'(w_acc >>> RND_SHIFT);

endmodule

// File: rtl/decompress_block.sv
// 8x8 block decompressor: load/dequantise, row IDCT, column IDCT, stream pixels.
// Dequantisation by the JPEG table is compiled in only when DECOMPRESS_DEQUANT_EN is defined.
module decompress_block
    import decompress_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    decompress_block_if.slave io_blk
);

    state_t                      r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0]        r_idx;
    logic                        r_coef_in_ready;
    logic                        r_pix_out_valid;
    logic signed [PIX_WIDTH-1:0] r_pix_out;
    logic signed [DQ_WIDTH-1:0]  r_buf_a [NUM_COEF];
    logic signed [MID_WIDTH-1:0] r_buf_b [NUM_COEF];

    logic                        w_in_fire, w_out_fire, w_idx_last, w_idx_adv;
    logic [IDX_WIDTH-1:0]        w_idx_inc;
    logic [2:0]                  w_hi, w_lo;
    logic signed [DQ_WIDTH-1:0]  w_dq;
    logic signed [MID_WIDTH-1:0] w_dot_a [BLOCK_SIZE];
    logic signed [T_WIDTH-1:0]   w_dot_b [BLOCK_SIZE];
    logic signed [DOT_WIDTH-1:0] w_dot_y;
    logic signed [PIX_WIDTH-1:0] w_pix;

    assign w_in_fire  = io_blk.coef_in_valid & r_coef_in_ready;
    assign w_out_fire = r_pix_out_valid & io_blk.pix_out_ready;
    assign w_idx_last = (r_idx == IDX_WIDTH'(NUM_COEF - 1));
    assign w_idx_inc  = r_idx + IDX_WIDTH'(1);
    assign w_hi       = r_idx[IDX_WIDTH-1:3];
    assign w_lo       = r_idx[2:0];

`ifdef DECOMPRESS_DEQUANT_EN
    logic signed [DQ_WIDTH-1:0] w_q;
    assign w_q  = DQ_WIDTH'({1'b0, QTAB[r_idx]});
    assign w_dq = DQ_WIDTH'(io_blk.coef_in) * w_q;
`else
    assign w_dq = DQ_WIDTH'(io_blk.coef_in);
`endif

    // ROW: D[u][v]*T[v][x] over v with (u,x)=(hi,lo); COL: T[u][y]*R[u][x] over u with (y,x)=(hi,lo).
    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (r_state == S_COL) begin
                w_dot_a[i] = r_buf_b[{3'(i), w_lo}];
                w_dot_b[i] = TTAB[{3'(i), w_hi}];
            end else begin
                w_dot_a[i] = MID_WIDTH'(r_buf_a[{w_hi, 3'(i)}]);
                w_dot_b[i] = TTAB[{3'(i), w_lo}];
            end
        end
    end

    idct_dot8 u_dot (
        .i_a   (w_dot_a),
        .i_b   (w_dot_b),
        .o_y_c (w_dot_y)
    );

    assign w_pix = sat_pix(w_dot_y);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_adv   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_idx_adv = w_in_fire;
                if (w_in_fire && w_idx_last) w_state_nxt = S_ROW;
            end
            S_ROW: begin
                w_idx_adv = 1'b1;
                if (w_idx_last) w_state_nxt = S_COL;
            end
            S_COL: begin
                w_idx_adv = 1'b1;
                if (w_idx_last) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                w_idx_adv = w_out_fire;
                if (w_out_fire && w_idx_last) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // The pixel register is preloaded with P[0] as COL finishes, then with P[idx+1] on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_LOAD;
            r_idx           <= '0;
            r_coef_in_ready <= 1'b1;
            r_pix_out_valid <= 1'b0;
            r_pix_out       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_coef_in_ready <= (w_state_nxt == S_LOAD);
            r_pix_out_valid <= (w_state_nxt == S_OUT);
            if (w_idx_adv) r_idx <= w_idx_inc;
            if ((r_state == S_COL && w_idx_last) || (r_state == S_OUT && w_out_fire)) begin
                r_pix_out <= PIX_WIDTH'(r_buf_a[w_idx_inc]);
            end
        end
    end

    // Buffer A holds D during LOAD/ROW and is overwritten with saturated pixels during COL.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf_a[r_idx] <= w_dq;
        end else if (r_state == S_COL) begin
            r_buf_a[r_idx] <= DQ_WIDTH'(w_pix);
        end
        if (r_state == S_ROW) begin
            r_buf_b[r_idx] <= MID_WIDTH'(w_dot_y);
        end
    end

    assign io_blk.coef_in_ready = r_coef_in_ready;
    assign io_blk.pix_out_valid = r_pix_out_valid;
    assign io_blk.pix_out       = r_pix_out;
    // Pulses during the cycle of the 64th pixel handshake.
    assign io_blk.block_done    = r_pix_out_valid & w_idx_last & io_blk.pix_out_ready;

endmodule

// File: doc/decompress_block.md
# decompress_block

Single-block image decompressor: accepts one 8x8 block of quantized DCT levels in raster order, dequantizes them, runs a separable 2-D inverse DCT with one shared 8-way dot-product unit, and streams out 64 reconstructed signed pixels. It is the receive-side counterpart of the per-block compressor and produces the same signed Q9.0 pixel format the compressor consumes. Blocks are processed strictly one at a time; a block-level top instantiates one of these per block or time-shares it.

## Interface
- BLOCK_SIZE, 8: block edge; only 8 supported.
- COEF_WIDTH, 12: signed integer width of quantized input levels.
- DQ_WIDTH, 20: signed width of dequantized coefficient (COEF_WIDTH + 8).
- MID_WIDTH, 24: signed width of row-pass intermediate.
- PIX_WIDTH, 9: signed output pixel width (Q9.0).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coef_in_valid  in  1  input level valid.
- coef_in_ready  out  1  block accepts input; reset value 1.
- coef_in  in  COEF_WIDTH  signed quantized level, raster order (u row, v col).
- pix_out_valid  out  1  output pixel valid; reset value 0.
- pix_out_ready  in  1  downstream accepts pixel.
- pix_out  out  PIX_WIDTH  signed pixel, raster order (y row, x col); reset value 0.
- block_done  out  1  one-cycle pulse on the 64th pixel transfer; reset value 0.

## Operation
- States: LOAD (reset state), ROW, COL, OUT.
- LOAD: coef_in_ready=1. Each transfer (valid & ready) stores D[k] = coef_in * QTAB[k] into buffer A at index k; k increments 0..63. After transfer 63, go to ROW, k cleared.
- ROW: 64 cycles, one output per cycle, index (u,x) raster. R[u][x] = round(sum_v D[u][v]*T[v][x]) >> 14, stored in buffer B (MID_WIDTH).
- COL: 64 cycles, index (y,x) raster. P[y][x] = round(sum_u T[u][y]*R[u][x]) >> 14, saturated to [-256, 255], stored in buffer A low PIX_WIDTH bits.
- OUT: pix_out_valid=1, pix_out = P[current index]. Index advances on each transfer. On transfer 63: block_done=1 that cycle, next state LOAD.
- T[k][n] = c(k)/2 * cos((2n+1)k*pi/16), c(0)=1/sqrt2, else 1; stored as signed 16-bit Q1.14 rounded to nearest (T[0][n]=5793).
- Rounding: add 2^13, arithmetic shift right 14 (round half toward +inf). Products/accumulators sized with no intermediate overflow (≥40 bits).
- coef_in_ready=0 in ROW, COL, OUT; pix_out_valid=0 in LOAD, ROW, COL. No overlap of input and output phases.
- Backpressure: while pix_out_valid & !pix_out_ready, pix_out and index hold.
- Reset mid-operation: any state returns to LOAD, counters 0, partial block discarded; buffers need not be cleared.

## Timing
- Last input transfer in cycle t -> ROW cycles t+1..t+64, COL t+65..t+128, pix_out_valid rises at t+129 with P[0][0].
- Minimum block period with no stalls: 64 + 128 + 64 = 256 cycles.
- Outputs registered; coef_in_ready and pix_out_valid decoded from the state register only.

## Configuration
- DECOMPRESS_DEQUANT_EN defined: D[k] = coef_in * QTAB[k] (standard JPEG luminance table, QTAB[0]=16).
- Undefined: D[k] = sign-extended coef_in; no multiplier or table; IDCT path unchanged.

## Structure
- Package decompress_pkg: state enum, widths, QTAB[64] (8-bit unsigned), T[8][8] (Q1.14), rounding shift constant 14.
- Sub-module idct_dot8: combinational 8-way signed multiply-accumulate with round-and-shift; shared by ROW and COL via operand muxing.

## Test plan
- Reset: during and after rst_n low -> coef_in_ready=1, pix_out_valid=0, pix_out=0, block_done=0.
- DC only, macro on: coef[0]=8, rest 0 -> D=128, R row0=45, all 64 pixels=16; first pixel valid exactly 129 cycles after last input.
- All-zero block -> 64 pixels of 0, block_done pulses once on 64th transfer, coef_in_ready returns to 1 next cycle.
- Saturation: coef[0]=-2048, macro on -> all pixels -256; coef[0]=2047 -> all pixels 255.
- Backpressure: drop pix_out_ready for 10 cycles after pixel 20 -> pix_out holds pixel 21 value, no pixel lost or duplicated, coef_in_ready stays 0.
- Reset after 30 inputs, then full DC block coef[0]=8 -> output all 16; macro off with coef[0]=128 -> all 16.
